// File: rtl/lcd_timing_monitor.sv
// lcd_timing_monitor: measures panel video timing per frame and reports conformity, lock state and bad-frame count
//   clk_i/rst_i: pixel clock, async active-high reset
//   lcd_de_i/lcd_hsync_i/lcd_vsync_i, lcd_r_i/g_i/b_i: panel timing and RGB565 pixel data
//   meas_*_o, frame_sum_o: last completed frame; frame_done_o pulses when they update
//   frame_ok_o, locked_o, err_cnt_o: conformity of last frame, stable-timing flag, bad-frame count
module lcd_timing_monitor #(
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 600,
  parameter int H_TOTAL     = 1344,
  parameter int V_TOTAL     = 635,
  parameter int SYNC_POL    = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lcd_de_i,
  input  logic        lcd_hsync_i,
  input  logic        lcd_vsync_i,
  input  logic [4:0]  lcd_r_i,
  input  logic [5:0]  lcd_g_i,
  input  logic [4:0]  lcd_b_i,
  output logic [11:0] meas_hact_o,
  output logic [11:0] meas_vact_o,
  output logic [11:0] meas_htotal_o,
  output logic [11:0] meas_vtotal_o,
  output logic [15:0] frame_sum_o,
  output logic        frame_done_o,
  output logic        frame_ok_o,
  output logic        locked_o,
  output logic [7:0]  err_cnt_o
);
  localparam logic ACT = SYNC_POL != 0;
  localparam logic [11:0] MAX = 12'hFFF;
  localparam logic [11:0] HA = 12'(H_ACTIVE);
  localparam logic [11:0] VA = 12'(V_ACTIVE);
  localparam logic [11:0] HT = 12'(H_TOTAL);
  localparam logic [11:0] VT = 12'(V_TOTAL);
  localparam logic [3:0] LF = 4'(LOCK_FRAMES);
  typedef enum logic {SEEK, MEASURE} state_e;
  state_e state_q, state_d;
  logic s1_de_q, s1_hs_q, s1_vs_q, s2_hs_q, s2_vs_q;
  logic [15:0] s1_pix_q;
  logic [11:0] line_q, line_d, de_q, de_d, vact_q, vact_d, vtot_q, vtot_d, hact_q, hact_d, htot_q, htot_d;
  logic [15:0] sum_q, sum_d;
  logic err_q, err_d, rec_q, rec_d, seen_q, seen_d;
  logic [3:0] streak_q, streak_d;
  logic [11:0] m_hact_q, m_hact_d, m_vact_q, m_vact_d, m_htot_q, m_htot_d, m_vtot_q, m_vtot_d;
  logic [15:0] m_sum_q, m_sum_d;
  logic done_q, done_d, ok_q, ok_d, locked_q, locked_d;
  logic [7:0] errc_q, errc_d;
  logic hs_e, vs_e, fin, act_close, rec, line_err, good;
  logic [11:0] vact_c, hact_c, htot_c;
  // *_c values are the old frame's totals including a line closed this cycle, so an
  // HSYNC edge coincident with VSYNC closes into the old frame but counts as line 1 of the new one
  always_comb begin
    hs_e = s1_hs_q == ACT && s2_hs_q != ACT;
    vs_e = s1_vs_q == ACT && s2_vs_q != ACT;
    fin = vs_e && state_q == MEASURE;
    act_close = hs_e && de_q != '0;
    rec = hs_e && seen_q;
    line_err = (act_close && de_q != HA) || (rec && line_q != HT);
    vact_c = vact_q + {11'd0, act_close && vact_q != MAX};
    hact_c = act_close ? de_q : hact_q;
    htot_c = rec ? line_q : htot_q;
    good = !(err_q || line_err) && vact_c == VA && vtot_q == VT && (rec_q || rec);
    state_d = vs_e ? MEASURE : state_q;
    line_d = hs_e ? 12'd1 : line_q + {11'd0, line_q != MAX};
    de_d = hs_e ? {11'd0, s1_de_q} : de_q + {11'd0, s1_de_q && de_q != MAX};
    seen_d = seen_q || (hs_e && (state_q == MEASURE || vs_e));
    vact_d = vs_e ? '0 : vact_c;
    hact_d = vs_e ? '0 : hact_c;
    htot_d = vs_e ? '0 : htot_c;
    err_d = !vs_e && (err_q || line_err);
    rec_d = !vs_e && (rec_q || rec);
    vtot_d = vs_e ? {11'd0, hs_e} : vtot_q + {11'd0, hs_e && vtot_q != MAX};
    sum_d = (vs_e ? 16'd0 : sum_q) + (s1_de_q ? s1_pix_q : 16'd0);
    m_hact_d = fin ? hact_c : m_hact_q;
    m_vact_d = fin ? vact_c : m_vact_q;
    m_htot_d = fin ? htot_c : m_htot_q;
    m_vtot_d = fin ? vtot_q : m_vtot_q;
    m_sum_d = fin ? sum_q : m_sum_q;
    done_d = fin;
    ok_d = fin ? good : ok_q;
    streak_d = fin ? (good ? streak_q + {3'd0, streak_q != LF} : 4'd0) : streak_q;
    locked_d = fin ? good && streak_d == LF : locked_q;
    errc_d = errc_q + {7'd0, fin && !good && errc_q != 8'hFF};
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SEEK;
      s1_de_q <= 1'b0;
      s1_hs_q <= !ACT;
      s1_vs_q <= !ACT;
      s2_hs_q <= !ACT;
      s2_vs_q <= !ACT;
      s1_pix_q <= '0;
      line_q <= '0;
      de_q <= '0;
      vact_q <= '0;
      vtot_q <= '0;
      hact_q <= '0;
      htot_q <= '0;
      sum_q <= '0;
      err_q <= 1'b0;
      rec_q <= 1'b0;
      seen_q <= 1'b0;
      streak_q <= '0;
      m_hact_q <= '0;
      m_vact_q <= '0;
      m_htot_q <= '0;
      m_vtot_q <= '0;
      m_sum_q <= '0;
      done_q <= 1'b0;
      ok_q <= 1'b0;
      locked_q <= 1'b0;
      errc_q <= '0;
    end else begin
      state_q <= state_d;
      s1_de_q <= lcd_de_i;
      s1_hs_q <= lcd_hsync_i;
      s1_vs_q <= lcd_vsync_i;
      s2_hs_q <= s1_hs_q;
      s2_vs_q <= s1_vs_q;
      s1_pix_q <= {lcd_r_i, lcd_g_i, lcd_b_i};
      line_q <= line_d;
      de_q <= de_d;
      vact_q <= vact_d;
      vtot_q <= vtot_d;
      hact_q <= hact_d;
      htot_q <= htot_d;
      sum_q <= sum_d;
      err_q <= err_d;
      rec_q <= rec_d;
      seen_q <= seen_d;
      streak_q <= streak_d;
      m_hact_q <= m_hact_d;
      m_vact_q <= m_vact_d;
      m_htot_q <= m_htot_d;
      m_vtot_q <= m_vtot_d;
      m_sum_q <= m_sum_d;
      done_q <= done_d;
      ok_q <= ok_d;
      locked_q <= locked_d;
      errc_q <= errc_d;
    end
  end
  assign meas_hact_o = m_hact_q;
  assign meas_vact_o = m_vact_q;
  assign meas_htotal_o = m_htot_q;
  assign meas_vtotal_o = m_vtot_q;
  assign frame_sum_o = m_sum_q;
  assign frame_done_o = done_q;
  assign frame_ok_o = ok_q;
  assign locked_o = locked_q;
  assign err_cnt_o = errc_q;
endmodule

// File: tb/tb_lcd_timing_monitor.sv
// tb_lcd_timing_monitor: randomized frame stimulus checked every cycle against an interval-arithmetic frame model
module tb_lcd_timing_monitor;
  localparam int HA = 8, VA = 4, HT = 12, VT = 6, SP = 0, LF = 2;
  localparam logic ACT = SP != 0;
  logic clk = 1'b0, rst = 1'b1, de = 1'b0, hs = !ACT, vs = !ACT;
  logic [15:0] pix = '0;
  logic [11:0] m_hact, m_vact, m_htot, m_vtot;
  logic [15:0] f_sum;
  logic f_done, f_ok, lkd;
  logic [7:0] e_cnt;
  lcd_timing_monitor #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
                       .SYNC_POL(SP), .LOCK_FRAMES(LF)) dut (
    .clk_i(clk), .rst_i(rst), .lcd_de_i(de), .lcd_hsync_i(hs), .lcd_vsync_i(vs),
    .lcd_r_i(pix[15:11]), .lcd_g_i(pix[10:5]), .lcd_b_i(pix[4:0]),
    .meas_hact_o(m_hact), .meas_vact_o(m_vact), .meas_htotal_o(m_htot), .meas_vtotal_o(m_vtot),
    .frame_sum_o(f_sum), .frame_done_o(f_done), .frame_ok_o(f_ok), .locked_o(lkd), .err_cnt_o(e_cnt));
  always #5 clk = ~clk;
  typedef struct {
    int due;
    logic [11:0] hact, vact, htot, vtot;
    logic [15:0] sum;
    logic ok, locked;
    logic [7:0] errc;
  } rec_t;
  rec_t pend[$];
  rec_t ex;
  int vectors = 0, miscompares = 0, done_cnt = 0;
  int t = 0, t_cur = -10;
  bit prev_hs_a, prev_vs_a, meas;
  int a0, a_start, fi, de_pref, streak, errc_m;
  logic [15:0] sum_pref, sum_a;
  int e_t[$];
  int e_de[$];
  function automatic int mn(input int a, input int b);
    return a < b ? a : b;
  endfunction
  task automatic lit(input string nm, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask
  task automatic model_reset();
    pend.delete();
    e_t.delete();
    e_de.delete();
    t = 0;
    prev_hs_a = 0;
    prev_vs_a = 0;
    meas = 0;
    a0 = 0;
    a_start = 0;
    fi = 0;
    de_pref = 0;
    streak = 0;
    errc_m = 0;
    sum_pref = '0;
    sum_a = '0;
  endtask
  // A frame spans samples [A,B): it owns HSYNC edges in [A,B) for VTOTAL and the lines closed by edges in (A,B]
  task automatic eval_frame(input int b);
    rec_t r;
    int vtot, vact, hact, htot;
    bit err, recd, ok;
    vtot = 0; vact = 0; hact = 0; htot = 0; err = 0; recd = 0;
    for (int i = (fi > 0 ? fi - 1 : 0); i < e_t.size(); i++)
      if (e_t[i] >= a_start && e_t[i] < b) vtot++;
    for (int i = fi; i < e_t.size(); i++) begin
      int p, pd, dn, per;
      p = i > 0 ? e_t[i-1] : 0;
      pd = i > 0 ? e_de[i-1] : 0;
      dn = mn(e_de[i] - pd, 4095);
      per = mn(e_t[i] - p, 4095);
      if (dn != 0) begin
        vact++;
        hact = dn;
        if (dn != HA) err = 1;
      end
      if (i > 0 && p >= a0) begin
        recd = 1;
        htot = per;
        if (per != HT) err = 1;
      end
    end
    vtot = mn(vtot, 4095);
    vact = mn(vact, 4095);
    ok = !err && vact == VA && vtot == VT && recd;
    if (ok) streak = mn(streak + 1, LF);
    else begin
      streak = 0;
      errc_m = mn(errc_m + 1, 255);
    end
    r.due = b + 1;
    r.hact = 12'(hact);
    r.vact = 12'(vact);
    r.htot = 12'(htot);
    r.vtot = 12'(vtot);
    r.sum = sum_pref - sum_a;
    r.ok = ok;
    r.locked = streak == LF;
    r.errc = 8'(errc_m);
    pend.push_back(r);
  endtask
  task automatic drive(input bit d, input bit h_a, input bit v_a, input logic [15:0] p);
    de = d;
    hs = h_a ? ACT : !ACT;
    vs = v_a ? ACT : !ACT;
    pix = p;
    if (h_a && !prev_hs_a) begin
      e_t.push_back(t);
      e_de.push_back(de_pref);
    end
    if (v_a && !prev_vs_a) begin
      if (meas) eval_frame(t);
      else begin
        meas = 1;
        a0 = t;
      end
      a_start = t;
      sum_a = sum_pref;
      fi = e_t.size();
    end
    prev_hs_a = h_a;
    prev_vs_a = v_a;
    if (d) begin
      de_pref++;
      sum_pref = sum_pref + p;
    end
    t_cur = t;
    t++;
  endtask
  task automatic step(input bit d, input bit h_a, input bit v_a, input logic [15:0] p);
    @(negedge clk);
    drive(d, h_a, v_a, p);
  endtask
  task automatic send_line(input int total, input int de_n, input bit v, input int pm);
    for (int c = 0; c < total; c++) begin
      bit d;
      logic [15:0] p;
      d = c >= 2 && c < 2 + de_n;
      p = 16'($urandom);
      if (d && pm == 1) p = 16'h0001;
      if (d && pm == 2) p = 16'hFFFF;
      step(d, c < 2, v, p);
    end
  endtask
  task automatic send_frame(input int bad_line, input int pm);
    for (int l = 0; l < 6; l++)
      send_line(HT, l < 4 ? (l == bad_line ? 7 : HA) : 0, l == 0, pm);
  endtask
  task automatic rand_frame();
    int nl;
    nl = $urandom_range(0, 9) < 8 ? 6 : int'($urandom_range(5, 7));
    for (int l = 0; l < nl; l++) begin
      int tot, dn;
      tot = $urandom_range(0, 9) < 9 ? 12 : int'($urandom_range(11, 13));
      if (l < 4) dn = $urandom_range(0, 9) < 9 ? 8 : int'($urandom_range(7, 9));
      else dn = $urandom_range(0, 19) < 19 ? 0 : 8;
      send_line(tot, dn, l == 0, 0);
    end
  endtask
  task automatic zero_chk();
    lit("rst_hact", int'(m_hact), 0);
    lit("rst_vact", int'(m_vact), 0);
    lit("rst_htot", int'(m_htot), 0);
    lit("rst_vtot", int'(m_vtot), 0);
    lit("rst_sum", int'(f_sum), 0);
    lit("rst_flags", int'({f_done, f_ok, lkd}), 0);
    lit("rst_errcnt", int'(e_cnt), 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    de = 1'b0;
    hs = !ACT;
    vs = !ACT;
    model_reset();
    repeat (3) @(negedge clk);
    zero_chk();
    rst = 1'b0;
    drive(0, 0, 0, '0);
  endtask
  always @(posedge clk) begin
    logic exp_done;
    #1;
    exp_done = 1'b0;
    if (rst) ex = '{default: 0};
    else if (pend.size() > 0 && pend[0].due == t_cur) begin
      ex = pend.pop_front();
      exp_done = 1'b1;
    end
    vectors++;
    if ({f_done, f_ok, lkd, e_cnt, m_hact, m_vact, m_htot, m_vtot, f_sum} !==
        {exp_done, ex.ok, ex.locked, ex.errc, ex.hact, ex.vact, ex.htot, ex.vtot, ex.sum}) begin
      miscompares++;
      $display("FAIL outputs t=%0d: got done=%0b ok=%0b lk=%0b err=%0d hact=%0d vact=%0d htot=%0d vtot=%0d sum=%h; want done=%0b ok=%0b lk=%0b err=%0d hact=%0d vact=%0d htot=%0d vtot=%0d sum=%h",
               t_cur, f_done, f_ok, lkd, e_cnt, m_hact, m_vact, m_htot, m_vtot, f_sum,
               exp_done, ex.ok, ex.locked, ex.errc, ex.hact, ex.vact, ex.htot, ex.vtot, ex.sum);
    end
    if (f_done === 1'b1) done_cnt++;
  end
  initial begin
    int d0;
    model_reset();
    repeat (3) @(negedge clk);
    zero_chk();
    rst = 1'b0;
    drive(0, 0, 0, '0);
    repeat (3) step(0, 0, 0, '0);
    repeat (3) send_frame(-1, 0);
    lit("three_frames_done_cnt", done_cnt, 2);
    lit("good_hact", int'(m_hact), 8);
    lit("good_vact", int'(m_vact), 4);
    lit("good_htot", int'(m_htot), 12);
    lit("good_vtot", int'(m_vtot), 6);
    lit("good_ok", int'(f_ok), 1);
    lit("good_locked", int'(lkd), 1);
    lit("good_errcnt", int'(e_cnt), 0);
    send_frame(2, 0);
    send_frame(-1, 0);
    lit("bad_ok", int'(f_ok), 0);
    lit("bad_locked", int'(lkd), 0);
    lit("bad_errcnt", int'(e_cnt), 1);
    send_frame(-1, 0);
    lit("relock1_locked", int'(lkd), 0);
    lit("relock1_ok", int'(f_ok), 1);
    send_frame(-1, 0);
    lit("relock2_locked", int'(lkd), 1);
    send_frame(-1, 1);
    send_frame(-1, 2);
    lit("sum_ones", int'(f_sum), 32);
    rand_frame();
    lit("sum_ffff", int'(f_sum), 16'hFFE0);
    repeat (30) rand_frame();
    send_frame(-1, 0);
    repeat (5000) step(0, 0, 0, 16'($urandom));
    send_frame(-1, 0);
    lit("gap_htot", int'(m_htot), 4095);
    lit("gap_ok", int'(f_ok), 0);
    send_line(HT, HA, 1, 0);
    repeat (4100) begin
      step(0, 1, 0, '0);
      step(0, 0, 0, '0);
    end
    send_frame(-1, 0);
    lit("short_vtot", int'(m_vtot), 4095);
    lit("short_htot", int'(m_htot), 2);
    lit("short_ok", int'(f_ok), 0);
    send_line(HT, HA, 1, 0);
    send_line(HT, HA, 0, 0);
    send_line(HT, HA, 0, 0);
    do_reset();
    d0 = done_cnt;
    repeat (2) step(0, 0, 0, '0);
    send_frame(-1, 0);
    lit("post_rst_no_done", done_cnt - d0, 0);
    send_frame(-1, 0);
    lit("post_rst_one_done", done_cnt - d0, 1);
    repeat (1000) begin
      step(0, 1, 1, 16'($urandom));
      step(0, 0, 0, '0);
      step(0, 0, 0, '0);
      step(0, 0, 0, '0);
    end
    repeat (3) step(0, 0, 0, '0);
    lit("errcnt_sat", int'(e_cnt), 255);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
